// File: rtl/cgra_test_sequencer_pkg.sv
// Shared types and constants for the CGRA test sequencer.
// Holds the sequencer state and stimulus mode enums plus the CRC-16 step helper.
package cgra_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_DRAIN,
        ST_RUN,
        ST_DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'd0,
        MODE_INC  = 2'd1,
        MODE_DEC  = 2'd2,
        MODE_ZERO = 2'd3
    } stim_mode_t;

    localparam logic [31:0] CFG_NOP_ADDR = 32'h0000_0000;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;

    // One CRC-16-CCITT update over a 16-bit sample, MSB first.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [15:0] data);
        logic [15:0] c;
        c = crc;
        for (int unsigned i = 0; i < 16; i++) begin
            if (c[15] ^ data[15 - i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
            else                      c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/cgra_test_sequencer_if.sv
// Config-word stream bundle between a host/ROM and the test sequencer.
interface cgra_cfg_if #(
    parameter int ADDR_W = 32,
    parameter int CFG_W  = 32
);
    logic              valid;
    logic              ready;
    logic              last;
    logic [ADDR_W-1:0] addr;
    logic [CFG_W-1:0]  data;

    modport master (output valid, output addr, output data, output last, input ready);
    modport slave  (input valid, input addr, input data, input last, output ready);
endinterface

// File: rtl/cgra_test_sequencer_stim.sv
// Per-side stimulus generator: loads a seed, then steps HOLD/INC/DEC/ZERO each enabled cycle.
module cgra_stim_gen
    import cgra_test_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              load,
    input  logic              step,
    input  stim_mode_t        mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] value
);
    logic [DATA_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (step) begin
            unique case (mode)
                MODE_HOLD: value_d = seed;
                MODE_INC:  value_d = value_q + DATA_W'(1);
                MODE_DEC:  value_d = value_q - DATA_W'(1);
                MODE_ZERO: value_d = '0;
                default:   value_d = value_q;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) value_q <= '0;
        else           value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/cgra_test_sequencer.sv
// Config-load and stimulus sequencer for full-system CGRA tests.
// Define CGRA_SEQ_CRC_EN to use a CRC-16-CCITT signature instead of rotate-xor.
module cgra_test_sequencer
    import cgra_test_pkg::*;
#(
    parameter int NUM_SIDES = 4,
    parameter int DATA_W    = 16,
    parameter int CYC_W     = 32,
    parameter int ADDR_W    = 32,
    parameter int CFG_W     = 32,
    parameter int SIDE_W    = (NUM_SIDES > 1) ? $clog2(NUM_SIDES) : 1
) (
    input  logic                        clk_in,
    input  logic                        reset_in,
    input  logic                        start_in,
    input  logic                        cfg_valid_in,
    output logic                        cfg_ready_out,
    input  logic [ADDR_W-1:0]           cfg_addr_in,
    input  logic [CFG_W-1:0]            cfg_data_in,
    input  logic                        cfg_last_in,
    output logic [ADDR_W-1:0]           config_addr_out,
    output logic [CFG_W-1:0]            config_data_out,
    input  logic [2*NUM_SIDES-1:0]      mode_in,
    input  logic [DATA_W*NUM_SIDES-1:0] seed_in,
    input  logic [CYC_W-1:0]            run_cycles_in,
    output logic [DATA_W*NUM_SIDES-1:0] pad_drive_out,
    input  logic [DATA_W*NUM_SIDES-1:0] pad_obs_in,
    input  logic [SIDE_W-1:0]           cap_side_in,
    output logic                        cap_valid_out,
    output logic [DATA_W-1:0]           cap_data_out,
    output logic [DATA_W-1:0]           signature_out,
    output logic [CYC_W-1:0]            cycle_count_out,
    output logic                        busy_out,
    output logic                        done_out
);
    seq_state_t state_q, state_d;

    logic [2*NUM_SIDES-1:0]      mode_q;
    logic [DATA_W*NUM_SIDES-1:0] seed_q;
    logic [CYC_W-1:0]            budget_q, count_q;
    logic [SIDE_W-1:0]           side_q;
    logic [ADDR_W-1:0]           cfg_addr_q;
    logic [CFG_W-1:0]            cfg_data_q;
    logic [DATA_W-1:0]           cap_data_q, sig_q, sig_next, sample;
    logic                        cap_valid_q;

    logic start_accept, cfg_accept, last_run, load_seeds, step_stim;

`ifdef CGRA_SEQ_CRC_EN
    if (DATA_W != 16) begin : g_crc_width_check
        $error("CGRA_SEQ_CRC_EN requires DATA_W == 16");
    end
    localparam logic [DATA_W-1:0] SIG_INIT = CRC_INIT;
    assign sig_next = crc16_step(sig_q, sample);
`else
    localparam logic [DATA_W-1:0] SIG_INIT = '0;
    assign sig_next = {sig_q[DATA_W-2:0], sig_q[DATA_W-1]} ^ sample;
`endif

    assign sample = pad_obs_in[int'(side_q) * DATA_W +: DATA_W];

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state_q <= ST_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start_in) state_d = ST_CONFIG;
            ST_CONFIG:        if (cfg_valid_in && cfg_last_in) state_d = ST_DRAIN;
            ST_DRAIN:         state_d = (budget_q == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (last_run) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cfg_ready_out = (state_q == ST_CONFIG);
        busy_out      = (state_q == ST_CONFIG) || (state_q == ST_DRAIN) || (state_q == ST_RUN);
        done_out      = (state_q == ST_DONE);
        start_accept  = start_in && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        cfg_accept    = cfg_ready_out && cfg_valid_in;
        last_run      = (state_q == ST_RUN) && (count_q == budget_q - CYC_W'(1));
        load_seeds    = (state_q == ST_DRAIN);
        // The final RUN cycle does not step, so DONE keeps the last driven value.
        step_stim     = (state_q == ST_RUN) && !last_run;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            mode_q      <= '0;
            seed_q      <= '0;
            budget_q    <= '0;
            side_q      <= '0;
            count_q     <= '0;
            cfg_addr_q  <= '0;
            cfg_data_q  <= '0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            sig_q       <= '0;
        end else begin
            cfg_addr_q  <= ADDR_W'(CFG_NOP_ADDR);
            cfg_data_q  <= '0;
            if (cfg_accept) begin
                cfg_addr_q <= cfg_addr_in;
                cfg_data_q <= cfg_data_in;
            end
            if (start_accept) begin
                mode_q   <= mode_in;
                seed_q   <= seed_in;
                budget_q <= run_cycles_in;
                side_q   <= cap_side_in;
                count_q  <= '0;
                sig_q    <= SIG_INIT;
            end
            if (state_q == ST_RUN) begin
                count_q    <= count_q + CYC_W'(1);
                cap_data_q <= sample;
                sig_q      <= sig_next;
            end
            // Valid trails each capture by one cycle but drops together with RUN.
            cap_valid_q <= (state_q == ST_RUN) && (state_d == ST_RUN);
        end
    end

    for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
        cgra_stim_gen #(.DATA_W(DATA_W)) u_stim (
            .clk_in   (clk_in),
            .reset_in (reset_in),
            .load     (load_seeds),
            .step     (step_stim),
            .mode     (stim_mode_t'(mode_q[2*s +: 2])),
            .seed     (seed_q[s*DATA_W +: DATA_W]),
            .value    (pad_drive_out[s*DATA_W +: DATA_W])
        );
    end

    assign config_addr_out = cfg_addr_q;
    assign config_data_out = cfg_data_q;
    assign cap_valid_out   = cap_valid_q;
    assign cap_data_out    = cap_data_q;
    assign signature_out   = sig_q;
    assign cycle_count_out = count_q;
endmodule
